pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//   Owns the fetch PC register of the pipelined core and sequences its updates:
//   sequential (+4), taken branch, jump, hazard stall.
//   Sits between the hazard/branch logic (ID stage) and instruction memory (IF).
//   Captures a redirect that arrives during a stall and applies it when the stall releases.
//   Generates the IF/ID flush for every applied redirect.
// PARAMETERS
//   RESET_PC        32'h0000_0000  first fetch address after reset
//   PC_ALIGN_CHECK  1              1: word-align redirect targets and flag misalignment; 0: use target as-is
// PORTS
//   clk            in   1   clock, all state updates on posedge
//   rst            in   1   synchronous reset, active-high
//   stall          in   1   hazard unit: hold PC this cycle
//   branch_taken   in   1   ID stage: branch resolved taken (pulse)
//   branch_target  in   32  branch destination
//   jump           in   1   ID stage: jump decoded (pulse)
//   jump_target    in   32  jump destination
//   pc             out  32  current fetch address (registered)
//   pc_plus4       out  32  pc + 4 (combinational, mod 2^32)
//   if_valid       out  1   fetch at pc is meaningful
//   ifid_flush     out  1   squash the IF/ID entry at the next edge (combinational)
//   misalign_err   out  1   sticky: a misaligned target was seen
//   state          out  2   FSM state, for debug/bench
// BEHAVIOUR
//   - Reset (any cycle, including mid-stall or with a pending redirect):
//     state=BOOT, pc=RESET_PC, pend_valid=0, misalign_err=0.
//     Combinational outputs in BOOT: if_valid=0, ifid_flush=0.
//   - States: BOOT=2'd0, RUN=2'd1, HOLD=2'd2. 2'd3 is illegal and recovers to BOOT.
//   - Redirect select: branch_taken has priority over jump.
//     redir = branch_taken|jump; tgt = branch_taken ? branch_target : jump_target.
//   - Alignment: if PC_ALIGN_CHECK and tgt[1:0]!=0, the applied/captured target is
//     {tgt[31:2],2'b00} and misalign_err sets. It stays set until rst.
//   - BOOT: if_valid=0; stall and redirect inputs ignored; pc held; next state RUN.
//     The first fetch is therefore RESET_PC, one cycle after rst deasserts.
//   - RUN: if_valid=1.
//       stall: pc held; if redir, capture tgt into pend_target, pend_valid=1; go to HOLD.
//       !stall & redir: pc<=tgt; ifid_flush=1 this cycle; stay in RUN.
//       otherwise: pc<=pc+4.
//   - HOLD: if_valid=1, the same pc is refetched; ifid_flush=0 while stall=1.
//       stall & redir: the newer redirect overwrites pend_target.
//       !stall: a live redir wins over pending (pc<=tgt); else if pend_valid, pc<=pend_target;
//         either case sets ifid_flush=1 and clears pend_valid.
//         With no redirect, pc<=pc+4. Next state RUN.
//   - Latency: a redirect accepted in cycle T gives pc=target in cycle T+1.
//     A stall in cycle T holds pc through T+1.
//   - Wrap-around: pc+4 from 32'hFFFF_FFFC gives 32'h0000_0000, with no flag.
//   - ifid_flush is never asserted in BOOT or in any cycle where stall=1.
// TESTING
//   1. rst=1 for 2 cycles, then 0 -> BOOT cycle with pc=0x0, if_valid=0;
//      then pc=0x0, 0x4, 0x8 with if_valid=1.
//   2. At pc=0x8, branch_taken=1, target=0x40 for 1 cycle -> ifid_flush=1 that cycle;
//      pc=0x40, then 0x44.
//   3. branch_taken=1 (0x100) and jump=1 (0x200) in the same cycle -> pc=0x100, flush=1.
//   4. At pc=0x10, stall=1 for 2 cycles with jump to 0x80 in the first -> pc holds 0x10,
//      state=HOLD, flush=0; on release flush=1, then pc=0x80.
//   5. RESET_PC=32'hFFFF_FFF8, free run -> pc=0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
//   6. jump_target=0x103 -> pc=0x100, misalign_err=1 held until rst; rst asserted while
//      HOLD has a pending redirect -> pc=RESET_PC, pending discarded.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bus between the hazard/branch logic in ID and the fetch PC sequencer.
// The master side drives stall and redirects; the slave (sequencer) returns the fetch PC and status.
interface pc_sequencer_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        if_valid;
    logic        ifid_flush;
    logic        misalign_err;
    logic [1:0]  state;

    modport master (
        output stall, branch_taken, branch_target, jump, jump_target,
        input  pc, pc_plus4, if_valid, ifid_flush, misalign_err, state
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target,
        output pc, pc_plus4, if_valid, ifid_flush, misalign_err, state
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC register and its update sequencing: +4, branch/jump redirect, stall hold.
// A redirect seen during a stall is parked and applied when the stall releases.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter bit          PC_ALIGN_CHECK = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        BAD  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        pend_valid_q, pend_valid_d;
    logic        err_q, err_d;
    logic        if_valid, ifid_flush;

    logic        redir;
    logic [31:0] tgt;
    logic        tgt_misaligned;
    logic [31:0] tgt_aligned;

    // Branch outranks jump when both resolve in the same cycle.
    assign redir          = bus.branch_taken | bus.jump;
    assign tgt            = bus.branch_taken ? bus.branch_target : bus.jump_target;
    assign tgt_misaligned = PC_ALIGN_CHECK && (tgt[1:0] != 2'b00);
    assign tgt_aligned    = tgt_misaligned ? {tgt[31:2], 2'b00} : tgt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            pend_target_q <= 32'h0000_0000;
            pend_valid_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            pend_valid_q  <= pend_valid_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        pend_valid_d  = pend_valid_q;
        err_d         = err_q;
        if_valid      = 1'b0;
        ifid_flush    = 1'b0;

        if ((state_q == RUN || state_q == HOLD) && redir && tgt_misaligned)
            err_d = 1'b1;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if_valid = 1'b1;
                if (bus.stall) begin
                    if (redir) begin
                        pend_target_d = tgt_aligned;
                        pend_valid_d  = 1'b1;
                    end
                    state_d = HOLD;
                end else if (redir) begin
                    pc_d       = tgt_aligned;
                    ifid_flush = 1'b1;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            HOLD: begin
                if_valid = 1'b1;
                if (bus.stall) begin
                    if (redir) begin
                        pend_target_d = tgt_aligned;
                        pend_valid_d  = 1'b1;
                    end
                end else begin
                    // A redirect arriving on the release cycle is newer than the parked one.
                    state_d      = RUN;
                    pend_valid_d = 1'b0;
                    if (redir) begin
                        pc_d       = tgt_aligned;
                        ifid_flush = 1'b1;
                    end else if (pend_valid_q) begin
                        pc_d       = pend_target_q;
                        ifid_flush = 1'b1;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_q + 32'd4;
    assign bus.if_valid     = if_valid;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.misalign_err = err_q;
    assign bus.state        = state_q;

endmodule
